bpu_update_sched: RTL and testbench

Scheduler for the branch predictor's local-history table (PHT), which has one write port. It buffers resolved-branch updates from EX in a small FIFO and retires them as single-cycle read-modify-write operations. It arbitrates the table write port against the fetch-side predictor's per-cycle write, and optionally initialises every entry after reset.

---
 rtl/bpu_update_sched_if.sv | 31 +++
 rtl/bpu_update_sched.sv | 174 +++++++++++++++++
 tb/tb_bpu_update_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpu_update_sched_if.sv
// Handshake and table-port bundle for bpu_update_sched.
// master = surrounding pipeline/table side, slave = the scheduler.
interface bpu_update_sched_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int HASH_DEPTH = 5,
  parameter int PARA_WIDTH = 10
);
  logic                  ex_vld;
  logic [ADDR_WIDTH-1:0] ex_pc;
  logic                  ex_taken;
  logic                  ex_ready;
  logic                  if_req;
  logic                  if_gnt;
  logic [HASH_DEPTH-1:0] tbl_raddr;
  logic [PARA_WIDTH-1:0] tbl_rdata1;
  logic [PARA_WIDTH-1:0] tbl_rdata2;
  logic [1:0]            tbl_we;
  logic [HASH_DEPTH-1:0] tbl_waddr;
  logic [PARA_WIDTH-1:0] tbl_wdata;
  logic                  busy;

  modport master (
    output ex_vld, ex_pc, ex_taken, if_req, tbl_rdata1, tbl_rdata2,
    input  ex_ready, if_gnt, tbl_raddr, tbl_we, tbl_waddr, tbl_wdata, busy
  );

  modport slave (
    input  ex_vld, ex_pc, ex_taken, if_req, tbl_rdata1, tbl_rdata2,
    output ex_ready, if_gnt, tbl_raddr, tbl_we, tbl_waddr, tbl_wdata, busy
  );
endinterface

// File: rtl/bpu_update_sched.sv
// PHT update scheduler: queues resolved branches and retires them as one-cycle RMW
// writes, sharing the write port with fetch. Optional init sweep: BPU_INIT_SWEEP_EN.
module bpu_update_sched_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input logic             clk,
  input logic             rstn,
  input logic [CNT_W-1:0] count,
  input logic             pop,
  input logic             gnt,
  input logic             sweep,
  input logic [1:0]       we
);
  a_gnt_pop_excl: assert property (@(posedge clk) disable iff (!rstn) !(pop && gnt));
  a_count_range:  assert property (@(posedge clk) disable iff (!rstn) count <= CNT_W'(FIFO_DEPTH));
  a_dual_we_only_sweep: assert property (@(posedge clk) disable iff (!rstn) sweep || (we != 2'b11));
endmodule

module bpu_update_sched #(
  parameter int ADDR_WIDTH = 32,
  parameter int HASH_DEPTH = 5,
  parameter int PARA_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rstn,
  bpu_update_sched_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PARA_WIDTH-1:0] INIT_ENTRY = PARA_WIDTH'(10'h055);

  typedef struct packed {
    logic [HASH_DEPTH-1:0] idx;
    logic                  slot;
    logic                  taken;
  } upd_t;

  // Saturating update of the counter selected by hist, then shift the outcome into hist.
  function automatic logic [PARA_WIDTH-1:0] rmw_entry(input logic [PARA_WIDTH-1:0] old,
                                                     input logic taken);
    logic [1:0]            hist;
    logic [1:0]            ctr;
    logic [1:0]            nxt;
    logic [PARA_WIDTH-1:0] res;
    hist = old[PARA_WIDTH-1 -: 2];
    ctr  = old[{hist, 1'b0} +: 2];
    if (taken) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    res = old;
    res[{hist, 1'b0} +: 2] = nxt;
    res[PARA_WIDTH-1 -: 2] = {hist[0], taken};
    return res;
  endfunction

  upd_t                  fifo_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W:0]        count_r;
  logic                  sweep_s;
  logic                  run_s;
  logic [HASH_DEPTH-1:0] sweep_addr_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  ready_s;
  logic                  push_s;
  logic                  pop_s;
  upd_t                  head_s;
  logic [PARA_WIDTH-1:0] head_rdata_s;
  logic                  unused_s;

`ifdef BPU_INIT_SWEEP_EN
  localparam logic [0:0] ST_SWEEP = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]            state_r;
  logic [HASH_DEPTH-1:0] sweep_cnt_r;

  // Init sweep walks every index once, then hands the port over to update traffic.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_SWEEP;
      sweep_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_SWEEP: begin
          sweep_cnt_r <= sweep_cnt_r + HASH_DEPTH'(1);
          state_r     <= (sweep_cnt_r == {HASH_DEPTH{1'b1}}) ? ST_RUN : ST_SWEEP;
        end
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_RUN;
      endcase
    end
  end

  assign sweep_s      = (state_r == ST_SWEEP);
  assign sweep_addr_s = sweep_cnt_r;
`else
  assign sweep_s      = 1'b0;
  assign sweep_addr_s = '0;
`endif

  assign run_s    = !sweep_s;
  assign unused_s = ^{bus.ex_pc[ADDR_WIDTH-1:HASH_DEPTH+3], bus.ex_pc[1:0]};

  // Arbitration: a full queue beats fetch so it is guaranteed to leave full.
  always_comb begin
    full_s       = (count_r == CNT_FULL);
    empty_s      = (count_r == '0);
    head_s       = fifo_r[rd_ptr_r];
    head_rdata_s = head_s.slot ? bus.tbl_rdata2 : bus.tbl_rdata1;
    ready_s      = run_s && !full_s;
    push_s       = bus.ex_vld && ready_s;
    pop_s        = run_s && !empty_s && (full_s || !bus.if_req);
    bus.ex_ready  = ready_s;
    bus.if_gnt    = run_s && (empty_s || (!full_s && bus.if_req));
    bus.tbl_raddr = head_s.idx;
    bus.busy      = sweep_s;
    if (sweep_s) begin
      bus.tbl_we    = 2'b11;
      bus.tbl_waddr = sweep_addr_s;
      bus.tbl_wdata = INIT_ENTRY;
    end else if (pop_s) begin
      bus.tbl_we    = head_s.slot ? 2'b10 : 2'b01;
      bus.tbl_waddr = head_s.idx;
      bus.tbl_wdata = rmw_entry(head_rdata_s, head_s.taken);
    end else begin
      bus.tbl_we    = 2'b00;
      bus.tbl_waddr = head_s.idx;
      bus.tbl_wdata = '0;
    end
  end

  // Queue pointers and occupancy; reset discards anything still queued.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= {bus.ex_pc[HASH_DEPTH+2:3], bus.ex_pc[2], bus.ex_taken};
    end
  end

  bpu_update_sched_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (PTR_W+1)
  ) u_chk (
    .clk   (clk),
    .rstn  (rstn),
    .count (count_r),
    .pop   (pop_s),
    .gnt   (bus.if_gnt),
    .sweep (sweep_s),
    .we    (bus.tbl_we)
  );
endmodule

// File: tb/tb_bpu_update_sched.sv
// Self-checking bench for bpu_update_sched: directed scenarios plus a randomized run
// scored against a queue/array reference of the predictor update rules.
module tb_bpu_update_sched;
  localparam int AW = 32;
  localparam int HD = 5;
  localparam int PW = 10;
  localparam int FD = 4;
  localparam int NENT = 32;

  typedef struct { int idx; bit slot; bit tk; } upd_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [PW-1:0] mem1 [NENT];
  logic [PW-1:0] mem2 [NENT];

  bpu_update_sched_if #(.ADDR_WIDTH(AW), .HASH_DEPTH(HD), .PARA_WIDTH(PW)) bus ();

  bpu_update_sched #(
    .ADDR_WIDTH(AW), .HASH_DEPTH(HD), .PARA_WIDTH(PW), .FIFO_DEPTH(FD)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.tbl_rdata1 = mem1[bus.tbl_raddr];
  assign bus.tbl_rdata2 = mem2[bus.tbl_raddr];

  // Reference rule: counter ctr[hist] saturates toward the outcome, hist shifts in the outcome.
  function automatic logic [PW-1:0] next_entry(input logic [PW-1:0] e, input bit tk);
    int v, h, c;
    v = int'(e);
    h = v >> 8;
    c = (v >> (2 * h)) & 3;
    c = tk ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
    v = (v & ~(3 << (2 * h)) & 'hFF) | (c << (2 * h)) | ((((h & 1) << 1) | int'(tk)) << 8);
    return PW'(v);
  endfunction

  // Table write port model: commit whatever the DUT writes this cycle, then advance.
  task automatic step();
    if (bus.tbl_we[0]) mem1[bus.tbl_waddr] = bus.tbl_wdata;
    if (bus.tbl_we[1]) mem2[bus.tbl_waddr] = bus.tbl_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_vld = 1'b0;
    bus.ex_pc = '0;
    bus.ex_taken = 1'b0;
    bus.if_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
`ifdef BPU_INIT_SWEEP_EN
    repeat (NENT) @(posedge clk);
    #1;
`endif
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic tk);
    bus.ex_vld = 1'b1;
    bus.ex_pc = pc;
    bus.ex_taken = tk;
  endtask

  task automatic test_reset();
    logic e_busy, e_rdy, e_gnt;
    logic [1:0] e_we;
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
`ifdef BPU_INIT_SWEEP_EN
    e_busy = 1'b1; e_rdy = 1'b0; e_gnt = 1'b0; e_we = 2'b11;
`else
    e_busy = 1'b0; e_rdy = 1'b1; e_gnt = 1'b1; e_we = 2'b00;
`endif
    n_tests++; if (bus.busy !== e_busy) begin n_fail++; $display("FAIL reset_busy: got %b expected %b", bus.busy, e_busy); end
    n_tests++; if (bus.ex_ready !== e_rdy) begin n_fail++; $display("FAIL reset_ex_ready: got %b expected %b", bus.ex_ready, e_rdy); end
    n_tests++; if (bus.if_gnt !== e_gnt) begin n_fail++; $display("FAIL reset_if_gnt: got %b expected %b", bus.if_gnt, e_gnt); end
    n_tests++; if (bus.tbl_we !== e_we) begin n_fail++; $display("FAIL reset_tbl_we: got %b expected %b", bus.tbl_we, e_we); end
    step();
  endtask

`ifdef BPU_INIT_SWEEP_EN
  task automatic test_sweep();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    bus.ex_vld = 1'b1;
    for (int k = 0; k < NENT; k++) begin
      @(negedge clk);
      n_tests++; if (bus.tbl_we !== 2'b11 || bus.tbl_waddr !== HD'(k) || bus.tbl_wdata !== 10'h055) begin
        n_fail++; $display("FAIL sweep_write[%0d]: got we=%b addr=%0d data=%h expected we=11 addr=%0d data=055", k, bus.tbl_we, bus.tbl_waddr, bus.tbl_wdata, k);
      end
      n_tests++; if (bus.busy !== 1'b1 || bus.ex_ready !== 1'b0 || bus.if_gnt !== 1'b0) begin
        n_fail++; $display("FAIL sweep_flags[%0d]: got busy=%b rdy=%b gnt=%b expected 1 0 0", k, bus.busy, bus.ex_ready, bus.if_gnt);
      end
      step();
    end
    bus.ex_vld = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0 || bus.ex_ready !== 1'b1 || bus.tbl_we !== 2'b00) begin
      n_fail++; $display("FAIL sweep_done: got busy=%b rdy=%b we=%b expected 0 1 00", bus.busy, bus.ex_ready, bus.tbl_we);
    end
    step();
  endtask
`endif

  task automatic test_single_update();
    do_reset();
    mem1[1] = 10'h055;
    push(32'h1C00_0008, 1'b1);
    @(negedge clk);
    n_tests++; if (bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", bus.ex_ready); end
    step();
    bus.ex_vld = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.tbl_we !== 2'b01) begin n_fail++; $display("FAIL single_we: got %b expected 01", bus.tbl_we); end
    n_tests++; if (bus.tbl_waddr !== 5'd1) begin n_fail++; $display("FAIL single_waddr: got %0d expected 1", bus.tbl_waddr); end
    n_tests++; if (bus.tbl_wdata !== 10'h156) begin n_fail++; $display("FAIL single_wdata: got %h expected 156", bus.tbl_wdata); end
    step();
    @(negedge clk);
    n_tests++; if (bus.tbl_we !== 2'b00) begin n_fail++; $display("FAIL single_idle_we: got %b expected 00", bus.tbl_we); end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    mem1[2] = 10'h3FF;
    mem2[3] = 10'h000;
    push(32'h0000_0010, 1'b1);
    step();
    push(32'h0000_001C, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.tbl_we !== 2'b01 || bus.tbl_waddr !== 5'd2 || bus.tbl_wdata !== 10'h3FF) begin
      n_fail++; $display("FAIL sat_high: got we=%b addr=%0d data=%h expected 01 2 3ff", bus.tbl_we, bus.tbl_waddr, bus.tbl_wdata);
    end
    step();
    bus.ex_vld = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.tbl_we !== 2'b10 || bus.tbl_waddr !== 5'd3 || bus.tbl_wdata !== 10'h000) begin
      n_fail++; $display("FAIL sat_low: got we=%b addr=%0d data=%h expected 10 3 000", bus.tbl_we, bus.tbl_waddr, bus.tbl_wdata);
    end
    step();
  endtask

  task automatic test_contention();
    do_reset();
    bus.if_req = 1'b1;
    push(32'h0000_0028, 1'b1);
    @(negedge clk);
    n_tests++; if (bus.if_gnt !== 1'b1) begin n_fail++; $display("FAIL cont_empty_gnt: got %b expected 1", bus.if_gnt); end
    step();
    bus.ex_vld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++; if (bus.if_gnt !== 1'b1 || bus.tbl_we !== 2'b00) begin
        n_fail++; $display("FAIL cont_fetch_wins[%0d]: got gnt=%b we=%b expected 1 00", k, bus.if_gnt, bus.tbl_we);
      end
      step();
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.tbl_we !== 2'b01 || bus.tbl_waddr !== 5'd5) begin
      n_fail++; $display("FAIL cont_drain: got we=%b addr=%0d expected 01 5", bus.tbl_we, bus.tbl_waddr);
    end
    step();
    @(negedge clk);
    n_tests++; if (bus.tbl_we !== 2'b00) begin n_fail++; $display("FAIL cont_after: got %b expected 00", bus.tbl_we); end
    step();
  endtask

  task automatic test_full();
    do_reset();
    bus.if_req = 1'b1;
    for (int k = 0; k < FD; k++) begin
      push(AW'((k + 8) << 3), 1'b1);
      @(negedge clk);
      n_tests++; if (bus.ex_ready !== 1'b1 || bus.tbl_we !== 2'b00) begin
        n_fail++; $display("FAIL full_fill[%0d]: got rdy=%b we=%b expected 1 00", k, bus.ex_ready, bus.tbl_we);
      end
      step();
    end
    push(AW'(20 << 3), 1'b1);
    @(negedge clk);
    n_tests++; if (bus.ex_ready !== 1'b0 || bus.if_gnt !== 1'b0) begin
      n_fail++; $display("FAIL full_block: got rdy=%b gnt=%b expected 0 0", bus.ex_ready, bus.if_gnt);
    end
    n_tests++; if (bus.tbl_we !== 2'b01 || bus.tbl_waddr !== 5'd8) begin
      n_fail++; $display("FAIL full_forced_drain: got we=%b addr=%0d expected 01 8", bus.tbl_we, bus.tbl_waddr);
    end
    step();
    bus.ex_vld = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.ex_ready !== 1'b1 || bus.if_gnt !== 1'b1 || bus.tbl_we !== 2'b00) begin
      n_fail++; $display("FAIL full_release: got rdy=%b gnt=%b we=%b expected 1 1 00", bus.ex_ready, bus.if_gnt, bus.tbl_we);
    end
    step();
    bus.if_req = 1'b0;
    for (int k = 1; k < FD; k++) begin
      @(negedge clk);
      n_tests++; if (bus.tbl_we !== 2'b01 || bus.tbl_waddr !== HD'(k + 8)) begin
        n_fail++; $display("FAIL full_drain[%0d]: got we=%b addr=%0d expected 01 %0d", k, bus.tbl_we, bus.tbl_waddr, k + 8);
      end
      step();
    end
    @(negedge clk);
    n_tests++; if (bus.tbl_we !== 2'b00) begin n_fail++; $display("FAIL full_no_extra: got %b expected 00", bus.tbl_we); end
    step();
  endtask

  task automatic test_random();
    upd_t q[$];
    upd_t u;
    logic [PW-1:0] ref1 [NENT];
    logic [PW-1:0] ref2 [NENT];
    logic [PW-1:0] old_e, new_e;
    int qn, bad;
    bit full, drain;
    do_reset();
    for (int i = 0; i < NENT; i++) begin
      mem1[i] = PW'($urandom); ref1[i] = mem1[i];
      mem2[i] = PW'($urandom); ref2[i] = mem2[i];
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < 390) begin
        bus.ex_vld = ($urandom_range(0, 1) == 1);
        bus.ex_pc = AW'($urandom);
        bus.ex_taken = ($urandom_range(0, 1) == 1);
        bus.if_req = ($urandom_range(0, 9) < 4);
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      qn = q.size();
      full = (qn == FD);
      drain = (qn > 0) && (full || !bus.if_req);
      n_tests++; if (bus.ex_ready !== !full) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b (q=%0d)", cyc, bus.ex_ready, !full, qn);
      end
      if (bus.if_req || qn == 0 || full) begin
        n_tests++; if (bus.if_gnt !== ((qn == 0) || (!full && bus.if_req))) begin
          n_fail++; $display("FAIL rand_gnt[%0d]: got %b expected %b (q=%0d)", cyc, bus.if_gnt, (qn == 0) || (!full && bus.if_req), qn);
        end
      end
      if (drain) begin
        u = q.pop_front();
        old_e = u.slot ? ref2[u.idx] : ref1[u.idx];
        new_e = next_entry(old_e, u.tk);
        if (u.slot) ref2[u.idx] = new_e; else ref1[u.idx] = new_e;
        n_tests++; if (bus.tbl_we !== (u.slot ? 2'b10 : 2'b01) || bus.tbl_waddr !== HD'(u.idx) || bus.tbl_wdata !== new_e) begin
          n_fail++; $display("FAIL rand_drain[%0d]: got we=%b addr=%0d data=%h expected slot%0d addr=%0d data=%h", cyc, bus.tbl_we, bus.tbl_waddr, bus.tbl_wdata, u.slot, u.idx, new_e);
        end
      end else begin
        n_tests++; if (bus.tbl_we !== 2'b00) begin
          n_fail++; $display("FAIL rand_nodrain[%0d]: got we=%b expected 00", cyc, bus.tbl_we);
        end
      end
      if (!full && bus.ex_vld) begin
        u.idx = (int'(bus.ex_pc) >>> 3) & (NENT - 1);
        u.slot = bus.ex_pc[2];
        u.tk = bus.ex_taken;
        q.push_back(u);
      end
      step();
    end
    bad = 0;
    for (int i = 0; i < NENT; i++) begin
      if (mem1[i] !== ref1[i] || mem2[i] !== ref2[i]) bad++;
    end
    n_tests++; if (bad != 0 || q.size() != 0) begin
      n_fail++; $display("FAIL rand_table: got %0d differing entries, %0d left queued, expected 0 and 0", bad, q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.if_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(AW'((k + 12) << 3), 1'b0);
      step();
    end
    bus.ex_vld = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    bus.if_req = 1'b0;
`ifdef BPU_INIT_SWEEP_EN
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.tbl_waddr !== 5'd10) begin n_fail++; $display("FAIL mid_sweep_at10: got %0d expected 10", bus.tbl_waddr); end
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.tbl_waddr !== 5'd0 || bus.tbl_we !== 2'b11) begin
      n_fail++; $display("FAIL mid_sweep_restart: got addr=%0d we=%b expected 0 11", bus.tbl_waddr, bus.tbl_we);
    end
    repeat (NENT) @(posedge clk);
    #1;
`endif
    @(negedge clk);
    n_tests++; if (bus.tbl_we !== 2'b00 || bus.ex_ready !== 1'b1 || bus.if_gnt !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_empty: got we=%b rdy=%b gnt=%b expected 00 1 1", bus.tbl_we, bus.ex_ready, bus.if_gnt);
    end
    step();
    @(negedge clk);
    n_tests++; if (bus.tbl_we !== 2'b00) begin n_fail++; $display("FAIL mid_reset_still_empty: got %b expected 00", bus.tbl_we); end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    for (int i = 0; i < NENT; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    test_reset();
`ifdef BPU_INIT_SWEEP_EN
    test_sweep();
`endif
    test_single_update();
    test_saturation();
    test_contention();
    test_full();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
